// File: rtl/sync_debounce_edge.sv
// Resynchronises a raw level, debounces it and emits a registered level plus rise/fall pulses.
// Define TOGGLE_OUT_EN to add the Toggle output (inverts on every debounced rising edge).
module sync_debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic Clck,
  input  logic Rst_n,
  input  logic Din,
  input  logic En,
  output logic Q,
  output logic Rise,
  output logic Fall,
`ifdef TOGGLE_OUT_EN
  output logic Busy,
  output logic Toggle
`else
  output logic Busy
`endif
);

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], Din};
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE: begin
        if (En && (s != q_q)) begin
          // A single required sample needs no counting state at all.
          if (DEBOUNCE_CYCLES == 1) begin
            q_d    = s;
            rise_d = s;
            fall_d = ~s;
          end else begin
            state_d = COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      COUNT: begin
        if (s == q_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (En) begin
          if (cnt_q == CNT_LAST) begin
            q_d     = s;
            state_d = STABLE;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge Clck) begin
    if (!Rst_n) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign Q    = q_q;
  assign Rise = rise_q;
  assign Fall = fall_q;
  assign Busy = busy_q;

`ifdef TOGGLE_OUT_EN
  logic toggle_q, toggle_d;

  always_comb begin
    toggle_d = toggle_q ^ rise_d;
  end

  always_ff @(posedge Clck) begin
    if (!Rst_n) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign Toggle = toggle_q;
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: default instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_sync_debounce_edge;

  logic Clck;
  logic Rst_n;
  logic Din;
  logic En;
  logic Q0, Rise0, Fall0, Busy0;
  logic Q1, Rise1, Fall1, Busy1;
`ifdef TOGGLE_OUT_EN
  logic Tog0, Tog1;
`endif

  int   errors = 0;
  int   checks = 0;
  logic tog0   = 1'b0;
  logic tog1   = 1'b0;

  sync_debounce_edge u_dut0 (
    .Clck  (Clck),
    .Rst_n (Rst_n),
    .Din   (Din),
    .En    (En),
    .Q     (Q0),
    .Rise  (Rise0),
    .Fall  (Fall0),
`ifdef TOGGLE_OUT_EN
    .Busy  (Busy0),
    .Toggle(Tog0)
`else
    .Busy  (Busy0)
`endif
  );

  sync_debounce_edge #(.DEBOUNCE_CYCLES(1)) u_dut1 (
    .Clck  (Clck),
    .Rst_n (Rst_n),
    .Din   (Din),
    .En    (En),
    .Q     (Q1),
    .Rise  (Rise1),
    .Fall  (Fall1),
`ifdef TOGGLE_OUT_EN
    .Busy  (Busy1),
    .Toggle(Tog1)
`else
    .Busy  (Busy1)
`endif
  );

  initial Clck = 1'b0;
  always #3 Clck = ~Clck;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge Clck);
    #1;
  endtask

  // exp = {Q, Rise, Fall, Busy}
  task automatic chk0(input string tag, input int n, input logic [3:0] exp);
    checks++;
    assert ({Q0, Rise0, Fall0, Busy0} === exp) else begin
      errors++;
      $error("FAIL %s dut0 e%0d {Q,Rise,Fall,Busy} observed=%b expected=%b",
             tag, n, {Q0, Rise0, Fall0, Busy0}, exp);
    end
`ifdef TOGGLE_OUT_EN
    if (exp[2]) tog0 = ~tog0;
    checks++;
    assert (Tog0 === tog0) else begin
      errors++;
      $error("FAIL %s dut0 e%0d Toggle observed=%b expected=%b", tag, n, Tog0, tog0);
    end
`endif
  endtask

  task automatic chk1(input string tag, input int n, input logic [3:0] exp);
    checks++;
    assert ({Q1, Rise1, Fall1, Busy1} === exp) else begin
      errors++;
      $error("FAIL %s dut1 e%0d {Q,Rise,Fall,Busy} observed=%b expected=%b",
             tag, n, {Q1, Rise1, Fall1, Busy1}, exp);
    end
`ifdef TOGGLE_OUT_EN
    if (exp[2]) tog1 = ~tog1;
    checks++;
    assert (Tog1 === tog1) else begin
      errors++;
      $error("FAIL %s dut1 e%0d Toggle observed=%b expected=%b", tag, n, Tog1, tog1);
    end
`endif
  endtask

  // Clean level change with En=1: dut0 changes on edge 6, dut1 on edge 3.
  task automatic transition(input string tag, input logic nv);
    logic ov;
    ov  = ~nv;
    Din = nv;
    for (int n = 1; n <= 7; n++) begin
      step();
      chk0(tag, n, {((n >= 6) ? nv : ov), (n == 6) && nv, (n == 6) && !nv, (n >= 3) && (n <= 5)});
      chk1(tag, n, {((n >= 3) ? nv : ov), (n == 3) && nv, (n == 3) && !nv, 1'b0});
    end
  endtask

  // Din high for k edges starting from Q=0, then low again.
  task automatic bounce(input string tag, input int k);
    Din = 1'b1;
    for (int n = 1; n <= k + 4; n++) begin
      step();
      chk0(tag, n, {1'b0, 1'b0, 1'b0, (n >= 3) && (n <= k + 2)});
      chk1(tag, n, {(n >= 3) && (n <= k + 2), n == 3, n == k + 3, 1'b0});
      if (n == k) Din = 1'b0;
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    Din   = 1'b1;
    En    = 1'b1;

    // Reset held with Din=1
    for (int n = 1; n <= 3; n++) begin
      step();
      chk0("reset", n, 4'b0000);
      chk1("reset", n, 4'b0000);
    end
    Rst_n = 1'b1;
    transition("rst_release", 1'b1);

    // Clean steps
    transition("fall_a", 1'b0);
    transition("rise_b", 1'b1);
    transition("fall_b", 1'b0);

    // Bounce rejection, including one sample short of qualifying
    bounce("bounce2", 2);
    bounce("bounce3", 3);
    transition("rise_post_bounce", 1'b1);
    transition("fall_post_bounce", 1'b0);

    // En toggling 1,0,1,0,... during a rise
    Din = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      En = (n % 2 == 1);
      step();
      chk0("en_gate", n, {n >= 9, n == 9, 1'b0, (n >= 3) && (n <= 8)});
      chk1("en_gate", n, {n >= 3, n == 3, 1'b0, 1'b0});
    end
    En = 1'b1;
    transition("fall_post_gate", 1'b0);

    // En held low while the synchronised level differs: nothing moves
    En  = 1'b0;
    Din = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk0("en_off", n, 4'b0000);
      chk1("en_off", n, 4'b0000);
    end
    En = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk0("en_on", n, {n >= 4, n == 4, 1'b0, n <= 3});
      chk1("en_on", n, {1'b1, n == 1, 1'b0, 1'b0});
    end
    transition("fall_post_en", 1'b0);

    // Reset asserted mid-count
    Din = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step();
      chk0("mid_count", n, {1'b0, 1'b0, 1'b0, n == 3});
      chk1("mid_count", n, {n == 3, n == 3, 1'b0, 1'b0});
    end
    Rst_n = 1'b0;
    step();
    tog0 = 1'b0;
    tog1 = 1'b0;
    chk0("mid_reset", 4, 4'b0000);
    chk1("mid_reset", 4, 4'b0000);
    Rst_n = 1'b1;
    transition("mid_rst_release", 1'b1);
    transition("fall_final", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
